// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared types, opcode/funct3 encodings and the instruction-to-op decoder
// for the RV32I execute stage.
`default_nettype none

package alu_exec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_ZERO = 4'd10
    } alu_op_t;

    function automatic alu_op_t decode_op(
        input logic       alu_en,
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic       funct1
    );
        alu_op_t op;
        op = ALU_ZERO;
        if (!alu_en) begin
            op = ALU_ZERO;
        end else if (opcode == OP_LOAD || opcode == OP_STORE ||
                     opcode == OP_LUI  || opcode == OP_AUIPC) begin
            // Address generation and upper-immediate forms always add.
            op = ALU_ADD;
        end else begin
            case (funct3)
                F3_ADD:  op = (opcode == OP_REG && funct1) ? ALU_SUB : ALU_ADD;
                F3_SLL:  op = ALU_SLL;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_XOR:  op = ALU_XOR;
                F3_SR:   op = funct1 ? ALU_SRA : ALU_SRL;
                F3_OR:   op = ALU_OR;
                F3_AND:  op = ALU_AND;
                default: op = ALU_ZERO;
            endcase
        end
        return op;
    endfunction

    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_exec_core.sv
// alu_logic_core: combinational single-cycle ALU result; shift ops pass A through
// because nonzero shifts are performed iteratively by the caller.
`default_nettype none

module alu_logic_core
    import alu_exec_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    always_comb begin
        y = '0;
        case (alu_op_t'(op))
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(N-1){1'b0}}, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  y = a;
            default:  y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_exec.sv
// alu_exec: RV32I execute stage with valid/ready handshake; single-cycle logic/arith/compare
// ops and iterative one-bit-per-cycle shifts.
`default_nettype none

module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [N-1:0] DATA0,
    input  logic [N-1:0] DATA1,
    input  logic         ALU_EN,
    input  logic [6:0]   OPCODE,
    input  logic [2:0]   FUNCT3,
    input  logic         FUNCT1,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [N-1:0] RESULT,
    output logic         ZERO,
    output logic         BUSY
);

    localparam int SW = $clog2(N);

    state_t          state;
    state_t          state_next;
    alu_op_t         op_in;
    alu_op_t         shift_op;
    logic [N-1:0]    work;
    logic [N-1:0]    shifted;
    logic [SW-1:0]   count;
    logic [N-1:0]    core_y;
    logic            accept;
    logic            start_shift;
    logic            last_shift;

    assign op_in       = decode_op(ALU_EN, OPCODE, FUNCT3, FUNCT1);
    assign IN_READY    = (state == IDLE) || ((state == DONE) && OUT_READY);
    assign accept      = IN_VALID && IN_READY;
    assign start_shift = accept && is_shift(op_in) && (DATA1[SW-1:0] != '0);
    assign last_shift  = (state == SHIFT) && (count == SW'(1));

    alu_logic_core #(
        .N (N)
    ) u_core (
        .op (op_in),
        .a  (DATA0),
        .b  (DATA1),
        .y  (core_y)
    );

    // SRA keeps the sign bit in place, so the latched DATA0 MSB is replicated each step.
    always_comb begin
        shifted = {1'b0, work[N-1:1]};
        case (shift_op)
            ALU_SLL: shifted = {work[N-2:0], 1'b0};
            ALU_SRA: shifted = {work[N-1], work[N-1:1]};
            default: shifted = {1'b0, work[N-1:1]};
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = start_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (last_shift) state_next = DONE;
            end
            DONE: begin
                if (OUT_READY) begin
                    if (accept) state_next = start_shift ? SHIFT : DONE;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RESULT    <= '0;
            ZERO      <= 1'b0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            work      <= '0;
            count     <= '0;
            shift_op  <= ALU_ZERO;
        end else begin
            OUT_VALID <= (state_next == DONE);
            BUSY      <= (state_next == SHIFT);

            if (start_shift) begin
                work     <= DATA0;
                count    <= DATA1[SW-1:0];
                shift_op <= op_in;
            end else if (state == SHIFT) begin
                work  <= shifted;
                count <= count - SW'(1);
            end

            if (accept && !start_shift) begin
                RESULT <= core_y;
                ZERO   <= (core_y == '0);
            end else if (last_shift) begin
                RESULT <= shifted;
                ZERO   <= (shifted == '0);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed table-driven bench for alu_exec plus handshake and reset sequences.
`default_nettype none

module tb_alu_exec;

    logic        CLK;
    logic        RESET_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] DATA0;
    logic [31:0] DATA1;
    logic        ALU_EN;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic        FUNCT1;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic        ZERO;
    logic        BUSY;

    int passed = 0;
    int total  = 0;

    alu_exec #(.N(32)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .DATA0     (DATA0),
        .DATA1     (DATA1),
        .ALU_EN    (ALU_EN),
        .OPCODE    (OPCODE),
        .FUNCT3    (FUNCT3),
        .FUNCT1    (FUNCT1),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .ZERO      (ZERO),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // edges = clock edges after the accept edge before OUT_VALID is seen (0 for single-cycle ops).
    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        en;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f1;
        logic [31:0] exp;
        logic        expz;
        int          edges;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] d0, input logic [31:0] d1, input logic en,
                         input logic [6:0] opc, input logic [2:0] f3, input logic f1);
        DATA0    = d0;
        DATA1    = d1;
        ALU_EN   = en;
        OPCODE   = opc;
        FUNCT3   = f3;
        FUNCT1   = f1;
        IN_VALID = 1'b1;
    endtask

    task automatic run_vec(input int i);
        int edges;
        int busy_cnt;
        string nm;
        nm = $sformatf("v%0d", i);
        drive(vecs[i].d0, vecs[i].d1, vecs[i].en, vecs[i].opc, vecs[i].f3, vecs[i].f1);
        chk({nm, "_in_ready"}, {31'd0, IN_READY}, 32'd1);
        tick();
        IN_VALID = 1'b0;
        DATA0    = 32'hDEADBEEF;
        DATA1    = 32'hDEADBEEF;
        edges    = 0;
        busy_cnt = 0;
        while (!OUT_VALID && edges < 40) begin
            if (BUSY) busy_cnt++;
            tick();
            edges++;
        end
        chk({nm, "_edges"}, edges, vecs[i].edges);
        chk({nm, "_busy_cycles"}, busy_cnt, vecs[i].edges);
        chk({nm, "_result"}, RESULT, vecs[i].exp);
        chk({nm, "_zero"}, {31'd0, ZERO}, {31'd0, vecs[i].expz});
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    initial begin
        int stale;
        RESET_N   = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        DATA0     = '0;
        DATA1     = '0;
        ALU_EN    = 1'b0;
        OPCODE    = '0;
        FUNCT3    = '0;
        FUNCT1    = 1'b0;

        vecs[0]  = '{32'd5,        32'd7,        1'b1, 7'b0110011, 3'b000, 1'b0, 32'd12,       1'b0, 0};
        vecs[1]  = '{32'd5,        32'd5,        1'b1, 7'b0110011, 3'b000, 1'b1, 32'd0,        1'b1, 0};
        vecs[2]  = '{32'd5,        32'd5,        1'b1, 7'b0010011, 3'b000, 1'b1, 32'd10,       1'b0, 0};
        vecs[3]  = '{32'h80000000, 32'd4,        1'b1, 7'b0110011, 3'b101, 1'b1, 32'hF8000000, 1'b0, 4};
        vecs[4]  = '{32'h80000000, 32'd4,        1'b1, 7'b0110011, 3'b101, 1'b0, 32'h08000000, 1'b0, 4};
        vecs[5]  = '{32'h80000000, 32'd0,        1'b1, 7'b0110011, 3'b101, 1'b1, 32'h80000000, 1'b0, 0};
        vecs[6]  = '{32'hFFFFFFFF, 32'd1,        1'b1, 7'b0110011, 3'b010, 1'b0, 32'd1,        1'b0, 0};
        vecs[7]  = '{32'hFFFFFFFF, 32'd1,        1'b1, 7'b0110011, 3'b011, 1'b0, 32'd0,        1'b1, 0};
        vecs[8]  = '{32'd5,        32'd7,        1'b0, 7'b0110011, 3'b000, 1'b0, 32'd0,        1'b1, 0};
        vecs[9]  = '{32'd1,        32'd31,       1'b1, 7'b0010011, 3'b001, 1'b0, 32'h80000000, 1'b0, 31};
        vecs[10] = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 7'b0110011, 3'b100, 1'b0, 32'hFF00FF00, 1'b0, 0};
        vecs[11] = '{32'h12340000, 32'h00005678, 1'b1, 7'b0010011, 3'b110, 1'b0, 32'h12345678, 1'b0, 0};
        vecs[12] = '{32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 7'b0110011, 3'b111, 1'b0, 32'h0F000F00, 1'b0, 0};
        vecs[13] = '{32'h00001000, 32'hFFFFFFFC, 1'b1, 7'b0000011, 3'b010, 1'b1, 32'h00000FFC, 1'b0, 0};
        vecs[14] = '{32'h00000000, 32'h12345000, 1'b1, 7'b0110111, 3'b111, 1'b0, 32'h12345000, 1'b0, 0};
        vecs[15] = '{32'h7FFFFFF0, 32'h00000024, 1'b1, 7'b0010011, 3'b101, 1'b1, 32'h07FFFFFF, 1'b0, 4};
        vecs[16] = '{32'd3,        32'd5,        1'b1, 7'b0110011, 3'b000, 1'b1, 32'hFFFFFFFE, 1'b0, 0};

        tick();
        tick();
        chk("rst_result",    RESULT,              32'd0);
        chk("rst_zero",      {31'd0, ZERO},       32'd0);
        chk("rst_out_valid", {31'd0, OUT_VALID},  32'd0);
        chk("rst_busy",      {31'd0, BUSY},       32'd0);
        chk("rst_in_ready",  {31'd0, IN_READY},   32'd1);
        RESET_N = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) run_vec(i);

        // Backpressure: result held while OUT_READY is low, then same-edge accept.
        drive(32'd1, 32'd2, 1'b1, 7'b0110011, 3'b000, 1'b0);
        tick();
        IN_VALID = 1'b0;
        chk("hs_first_valid", {31'd0, OUT_VALID}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hs_hold_result", RESULT,              32'd3);
            chk("hs_hold_valid",  {31'd0, OUT_VALID},  32'd1);
            chk("hs_hold_ready",  {31'd0, IN_READY},   32'd0);
        end
        drive(32'd10, 32'd20, 1'b1, 7'b0110011, 3'b000, 1'b0);
        OUT_READY = 1'b1;
        #1;
        chk("hs_b2b_in_ready", {31'd0, IN_READY}, 32'd1);
        tick();
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        chk("hs_b2b_valid",  {31'd0, OUT_VALID}, 32'd1);
        chk("hs_b2b_result", RESULT,             32'd30);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("hs_drained", {31'd0, OUT_VALID}, 32'd0);

        // Reset during the second cycle of a 10-bit shift.
        drive(32'd1, 32'd10, 1'b1, 7'b0110011, 3'b001, 1'b0);
        tick();
        IN_VALID = 1'b0;
        tick();
        chk("rs_busy_before", {31'd0, BUSY}, 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("rs_result",    RESULT,             32'd0);
        chk("rs_busy",      {31'd0, BUSY},      32'd0);
        chk("rs_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rs_in_ready",  {31'd0, IN_READY},  32'd1);
        tick();
        RESET_N = 1'b1;
        tick();
        run_vec(0);
        stale = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (OUT_VALID || BUSY) stale++;
        end
        chk("rs_no_stale", stale, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_exec.md
# alu_exec

Execute stage directly downstream of the ALU operand-select stage. Takes the selected operand pair DATA0/DATA1, the ALU enable, and the instruction's OPCODE/FUNCT3/FUNCT1. It computes the RV32I integer result through a valid/ready handshake. Logic, arithmetic and compare ops complete in one cycle. Shifts run iteratively, one bit per cycle, to keep the datapath small. The result feeds writeback and load/store address generation.

## Interface
- N, 32, datapath width; shift amount is DATA1[4:0] for N=32 (log2(N) bits generally)
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous, active-low reset
- IN_VALID  input  1  operand bundle valid
- IN_READY  output  1  stage can accept a bundle
- DATA0, DATA1  input  N  operands from operand-select stage
- ALU_EN  input  1  operation enable from operand-select stage
- OPCODE  input  7  instruction opcode
- FUNCT3  input  3  instruction funct3
- FUNCT1  input  1  instruction bit 30 (SUB/SRA select)
- OUT_VALID  output  1  RESULT valid
- OUT_READY  input  1  consumer accepts RESULT
- RESULT  output  N  computed value
- ZERO  output  1  RESULT == 0
- BUSY  output  1  shift in progress

## Operation
- Accept occurs when IN_VALID & IN_READY on a rising edge. All inputs are latched at accept; inputs are don't-care afterwards.
- Op select:
  - ALU_EN=0: RESULT=0.
  - OPCODE 0000011, 0100011, 0110111 or 0010111: ADD.
  - Otherwise op is selected by FUNCT3.
- FUNCT3 decode:
  - 000: ADD; SUB only when OPCODE=0110011 and FUNCT1=1.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL if FUNCT1=0, SRA if FUNCT1=1.
  - 110: OR.
  - 111: AND.
- Width rules: ADD/SUB wrap modulo 2^N, no overflow flag. SLT/SLTU produce 0 or 1 zero-extended. SRA replicates the latched DATA0[N-1].
- States:
  - IDLE: IN_READY=1. On accept, go to SHIFT for a shift with shamt≠0; otherwise compute and go to DONE.
  - SHIFT: each cycle shifts the working register by 1 and decrements the counter. Leave for DONE on the cycle the counter reaches 1 (last shift applied). BUSY=1; IN_READY=0.
  - DONE: OUT_VALID=1. RESULT and ZERO are held stable until OUT_READY. When OUT_READY=1: with IN_VALID=1 perform a same-edge accept (back-to-back) following IDLE's rules; otherwise go to IDLE.
- IN_READY = (state==IDLE) | (state==DONE & OUT_READY).
- Boundary cases:
  - Shift with shamt=0 takes the single-cycle path; RESULT=DATA0.
  - shamt=31 takes 31 SHIFT cycles.
  - ZERO is derived from the registered RESULT.
- Reset, including mid-SHIFT, takes effect immediately and asynchronously:
  - state=IDLE.
  - RESULT=0, ZERO=0, OUT_VALID=0, BUSY=0, counter=0.
  - IN_READY=1 once in IDLE.
  - An in-flight shift is discarded and never appears at the output.

## Timing
- Non-shift op accepted at edge k: OUT_VALID=1 in the cycle after edge k (latency 1).
- Shift with amount s≥1 accepted at edge k: BUSY=1 for s cycles, then OUT_VALID=1 after edge k+s (latency s, max 31).
- Throughput: one non-shift op per cycle when OUT_READY is held high.
- While OUT_VALID=1 and OUT_READY=0, RESULT, ZERO and OUT_VALID are unchanged.
- All outputs are registered except IN_READY, which is combinational from state and OUT_READY.

## Structure
- Package alu_exec_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - FUNCT3 constants F3_ADD … F3_AND;
  - opcode constants OP_IMM=0010011, OP_REG=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_LUI=0110111, OP_AUIPC=0010111;
  - alu_op enum.
- Sub-module alu_logic_core is purely combinational. It maps alu_op, A and B to the single-cycle result. The FSM, shift counter and working register stay in alu_exec.

## Test plan
- ADD: DATA0=5, DATA1=7, OPCODE=0110011, FUNCT3=000, FUNCT1=0 -> RESULT=12, ZERO=0, OUT_VALID one cycle after accept.
- SUB vs ADDI: DATA0=DATA1=5, FUNCT1=1:
  - OPCODE=0110011 -> RESULT=0, ZERO=1.
  - OPCODE=0010011 -> RESULT=10.
- Shifts: DATA0=0x80000000, DATA1=4, FUNCT3=101:
  - FUNCT1=1 -> 0xF8000000 with BUSY high 4 cycles, OUT_VALID at accept+4.
  - FUNCT1=0 -> 0x08000000.
  - DATA1=0 -> 0x80000000 at latency 1.
- Compares: DATA0=0xFFFFFFFF, DATA1=1 -> SLT gives 1; SLTU gives 0.
- Handshake: OUT_READY low 3 cycles -> RESULT held, IN_READY=0. Then OUT_READY high with IN_VALID high -> same-edge accept, next result one cycle later. ALU_EN=0 -> RESULT=0.
- Reset: RESET_N low during cycle 2 of a 10-bit shift -> outputs 0 immediately, BUSY=0. After release, a new ADD completes normally and no stale shift result appears.
